// File: rtl/enet_tx_mac_if.sv
// Byte stream from the TX FIFO into the MII transmit engine.
//   s_valid : FIFO byte valid              (master -> slave)
//   s_data  : FIFO byte                    (master -> slave)
//   s_last  : last byte of the frame       (master -> slave)
//   s_ready : byte accepted when s_valid && s_ready (slave -> master)
interface enet_tx_mac_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_last;
  logic       s_ready;

  modport master (output s_valid, s_data, s_last, input s_ready);
  modport slave  (input s_valid, s_data, s_last, output s_ready);
endinterface

// File: rtl/enet_tx_mac.sv
// MII transmit engine (tx_clk domain). Pulls frame bytes from the TX FIFO
// stream and sends preamble, SFD, data, optional zero pad, optional CRC-32
// FCS, then the inter-frame gap.
// Ports:
//   tx_clk, rst_n          : clock, asynchronous active-low reset
//   ether_en, gts          : start enable / graceful stop, sampled in IDLE
//   crc_append, pad_en     : per-frame options, latched at PRE entry
//   s (slave modport)      : FIFO byte stream (valid/ready/last)
//   mii_txd/tx_en/tx_er    : MII transmit nibble interface, low nibble first
//   frame_done, underrun   : one-cycle completion / abort pulses
//   gts_ack                : high while stopped in IDLE due to gts
module enet_tx_mac #(
  parameter int IFG_NIBBLES    = 24,
  parameter int MIN_DATA_BYTES = 60
) (
  input  logic                tx_clk,
  input  logic                rst_n,
  input  logic                ether_en,
  input  logic                crc_append,
  input  logic                pad_en,
  input  logic                gts,
  enet_tx_mac_if.slave        s,
  output logic [3:0]          mii_txd,
  output logic                mii_tx_en,
  output logic                mii_tx_er,
  output logic                frame_done,
  output logic                underrun,
  output logic                gts_ack
);

  localparam logic [7:0]  PRE_LAST  = 8'd15;
  localparam logic [7:0]  FCS_LAST  = 8'd7;
  localparam logic [7:0]  IFG_LAST  = 8'(IFG_NIBBLES - 1);
  localparam logic [10:0] MIN_BYTES = 11'(MIN_DATA_BYTES);
  localparam logic [31:0] CRC_INIT  = 32'hFFFF_FFFF;

  // The state register names what is on the wire in the current cycle;
  // output registers are loaded from the next-state values so every output
  // lines up with the state it belongs to.
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DATA, S_PAD, S_FCS, S_ABORT, S_IFG
  } state_t;

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic        hi, hi_n;
  logic [7:0]  byte_q, byte_n;
  logic        last_q, last_n;
  logic [10:0] bcnt, bcnt_n;
  logic [31:0] crc, crc_n;
  logic        pad_l, pad_n;
  logic        crc_l, crcl_n;

  logic [3:0]  txd_n;
  logic        en_n, er_n, rdy_n, done_n, und_n, ack_n;
  logic        ready_q;
  logic        start;
  logic [3:0]  cur_nib;
  logic [31:0] fcs_sh;

  // Reflected CRC-32 advanced by one nibble, LSB first.
  function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] n);
    logic [31:0] r;
    r = c ^ {28'h0, n};
    for (int i = 0; i < 4; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  assign start   = ether_en && !gts && s.s_valid;
  assign s.s_ready = ready_q;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hi_n    = hi;
    byte_n  = byte_q;
    last_n  = last_q;
    bcnt_n  = bcnt;
    crc_n   = crc;
    pad_n   = pad_l;
    crcl_n  = crc_l;
    cur_nib = 4'h0;
    if (state == S_DATA) cur_nib = hi ? byte_q[7:4] : byte_q[3:0];

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_PRE;
          cnt_n   = '0;
          crc_n   = CRC_INIT;
          pad_n   = pad_en & crc_append;  // padding only ever with a MAC FCS
          crcl_n  = crc_append;
        end
      end
      S_PRE: begin
        if (cnt == PRE_LAST) begin
          // s_ready is high in the SFD cycle
          if (s.s_valid) begin
            state_n = S_DATA;
            hi_n    = 1'b0;
            byte_n  = s.s_data;
            last_n  = s.s_last;
            bcnt_n  = 11'd1;
          end else begin
            state_n = S_ABORT;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_DATA: begin
        crc_n = crc_nib(crc, cur_nib);
        if (!hi) begin
          hi_n = 1'b1;
        end else if (!last_q) begin
          // s_ready is high in this high-nibble cycle
          if (s.s_valid) begin
            hi_n   = 1'b0;
            byte_n = s.s_data;
            last_n = s.s_last;
            bcnt_n = sat_inc(bcnt);
          end else begin
            state_n = S_ABORT;
          end
        end else if (pad_l && (bcnt < MIN_BYTES)) begin
          state_n = S_PAD;
          hi_n    = 1'b0;
          bcnt_n  = sat_inc(bcnt);
        end else begin
          state_n = crc_l ? S_FCS : S_IFG;
          cnt_n   = '0;
        end
      end
      S_PAD: begin
        crc_n = crc_nib(crc, cur_nib);
        if (!hi) begin
          hi_n = 1'b1;
        end else if (bcnt >= MIN_BYTES) begin
          state_n = crc_l ? S_FCS : S_IFG;
          cnt_n   = '0;
        end else begin
          hi_n   = 1'b0;
          bcnt_n = sat_inc(bcnt);
        end
      end
      S_FCS: begin
        if (cnt == FCS_LAST) begin
          state_n = S_IFG;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      S_ABORT: begin
        state_n = S_IFG;
        cnt_n   = '0;
      end
      S_IFG: begin
        // The IDLE decision is taken on the last gap cycle so back-to-back
        // frames see exactly IFG_NIBBLES cycles of tx_en low.
        if (cnt == IFG_LAST) begin
          if (start) begin
            state_n = S_PRE;
            cnt_n   = '0;
            crc_n   = CRC_INIT;
            pad_n   = pad_en & crc_append;
            crcl_n  = crc_append;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    txd_n  = 4'h0;
    en_n   = 1'b0;
    er_n   = 1'b0;
    rdy_n  = 1'b0;
    done_n = 1'b0;
    und_n  = 1'b0;
    ack_n  = 1'b0;
    fcs_sh = (~crc_n) >> {cnt_n[2:0], 2'b00};

    case (state_n)
      S_IDLE: ack_n = gts;
      S_PRE: begin
        en_n  = 1'b1;
        txd_n = (cnt_n == PRE_LAST) ? 4'hD : 4'h5;
        rdy_n = (cnt_n == PRE_LAST);
      end
      S_DATA: begin
        en_n   = 1'b1;
        txd_n  = hi_n ? byte_n[7:4] : byte_n[3:0];
        rdy_n  = hi_n && !last_n;
        done_n = hi_n && last_n && !crcl_n;
      end
      S_PAD: en_n = 1'b1;
      S_FCS: begin
        en_n   = 1'b1;
        txd_n  = fcs_sh[3:0];
        done_n = (cnt_n == FCS_LAST);
      end
      S_ABORT: begin
        en_n  = 1'b1;
        er_n  = 1'b1;
        und_n = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      hi         <= 1'b0;
      last_q     <= 1'b0;
      bcnt       <= '0;
      crc        <= CRC_INIT;
      pad_l      <= 1'b0;
      crc_l      <= 1'b0;
      mii_txd    <= 4'h0;
      mii_tx_en  <= 1'b0;
      mii_tx_er  <= 1'b0;
      ready_q    <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      gts_ack    <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hi         <= hi_n;
      last_q     <= last_n;
      bcnt       <= bcnt_n;
      crc        <= crc_n;
      pad_l      <= pad_n;
      crc_l      <= crcl_n;
      mii_txd    <= txd_n;
      mii_tx_en  <= en_n;
      mii_tx_er  <= er_n;
      ready_q    <= rdy_n;
      frame_done <= done_n;
      underrun   <= und_n;
      gts_ack    <= ack_n;
    end
  end

  // Byte holding register: pure data, qualified by the FSM state.
  always_ff @(posedge tx_clk) begin
    byte_q <= byte_n;
  end

endmodule

// File: tb/tb_enet_tx_mac.sv
module tb_enet_tx_mac;
  localparam int IFG  = 24;
  localparam int MINB = 60;

  logic       tx_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ether_en = 1'b0;
  logic       crc_append = 1'b1;
  logic       pad_en = 1'b0;
  logic       gts = 1'b0;
  logic [3:0] mii_txd;
  logic       mii_tx_en, mii_tx_er, frame_done, underrun, gts_ack;

  enet_tx_mac_if sif();

  enet_tx_mac #(.IFG_NIBBLES(IFG), .MIN_DATA_BYTES(MINB)) dut (
    .tx_clk     (tx_clk),
    .rst_n      (rst_n),
    .ether_en   (ether_en),
    .crc_append (crc_append),
    .pad_en     (pad_en),
    .gts        (gts),
    .s          (sif.slave),
    .mii_txd    (mii_txd),
    .mii_tx_en  (mii_tx_en),
    .mii_tx_er  (mii_tx_er),
    .frame_done (frame_done),
    .underrun   (underrun),
    .gts_ack    (gts_ack)
  );

  always #5 tx_clk = ~tx_clk;

  typedef struct {
    int len;
    int rdy;
    int done;
    int und;
    int gap;
  } fexp_t;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] src_q[$];
  logic [7:0] fb[$];
  logic [7:0] wb[$];
  logic [3:0] nq[$];
  fexp_t      fq[$];
  bit         mon_en = 1'b0;
  bit         in_frame = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference FCS: byte-wise reflected CRC-32 over the on-wire payload.
  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (wb[i]) begin
      c = c ^ {24'h0, wb[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  // Queue the bytes in fb for the FIFO and push the expected wire image.
  task automatic send_frame(input bit pad, input bit crc, input int gap, input bit abort,
                            input bit use_lit, input logic [31:0] lit);
    fexp_t       f;
    logic [31:0] fcs;
    int          nb;
    nb = fb.size();
    pad_en = pad;
    crc_append = crc;
    repeat (15) nq.push_back(4'h5);
    nq.push_back(4'hD);
    wb.delete();
    foreach (fb[i]) begin
      wb.push_back(fb[i]);
      nq.push_back(fb[i][3:0]);
      nq.push_back(fb[i][7:4]);
    end
    if (!abort) begin
      if (pad && crc) begin
        while (wb.size() < MINB) begin
          wb.push_back(8'h00);
          nq.push_back(4'h0);
          nq.push_back(4'h0);
        end
      end
      if (crc) begin
        fcs = use_lit ? lit : ~ref_crc();
        for (int k = 0; k < 8; k++) nq.push_back(fcs[4*k +: 4]);
      end
    end
    f.len  = abort ? (16 + 2 * nb + 1) : (16 + 2 * wb.size() + (crc ? 8 : 0));
    f.rdy  = abort ? nb + 1 : nb;
    f.done = abort ? 0 : 1;
    f.und  = abort ? 1 : 0;
    f.gap  = gap;
    fq.push_back(f);
    for (int i = 0; i < nb; i++) src_q.push_back({(i == nb - 1) && !abort, fb[i]});
  endtask

  task automatic rand_bytes(input int n);
    fb.delete();
    for (int i = 0; i < n; i++) fb.push_back(8'($urandom));
  endtask

  task automatic wait_src_empty();
    int t = 0;
    while (src_q.size() > 0 && t < 2000) begin
      @(negedge tx_clk);
      t++;
    end
    if (t >= 2000) chk("src_drain_timeout", 1, 0);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((fq.size() > 0 || nq.size() > 0 || mii_tx_en) && t < 3000) begin
      @(negedge tx_clk);
      t++;
    end
    if (t >= 3000) chk("idle_timeout", 1, 0);
    repeat (30) @(negedge tx_clk);
  endtask

  // FIFO model: handshake observed mid-cycle, queue advanced after the edge.
  initial begin
    bit take;
    sif.s_valid = 1'b0;
    sif.s_data  = 8'h00;
    sif.s_last  = 1'b0;
    forever begin
      @(negedge tx_clk);
      take = sif.s_valid && sif.s_ready;
      @(posedge tx_clk);
      #1;
      if (take && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0) begin
        sif.s_valid = 1'b1;
        sif.s_data  = src_q[0][7:0];
        sif.s_last  = src_q[0][8];
      end else begin
        sif.s_valid = 1'b0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    fexp_t cur;
    bit    have;
    int    len, rdy, dn, un, gap;
    have = 1'b0;
    len = 0; rdy = 0; dn = 0; un = 0; gap = 0;
    forever begin
      @(negedge tx_clk);
      if (!mon_en) begin
        in_frame = 1'b0;
        gap = 0;
      end else if (mii_tx_en) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          len = 0; rdy = 0; dn = 0; un = 0;
          if (fq.size() == 0) begin
            have = 1'b0;
            chk("frame_expected", 0, 1);
          end else begin
            cur = fq.pop_front();
            have = 1'b1;
            if (cur.gap >= 0) chk("ifg_gap", gap, cur.gap);
          end
        end
        len++;
        rdy += int'(sif.s_ready);
        dn  += int'(frame_done);
        un  += int'(underrun);
        if (mii_tx_er) begin
          chk("er_txd", 32'(mii_txd), 0);
          chk("er_underrun", 32'(underrun), 1);
        end else if (nq.size() == 0) begin
          chk("nibble_expected", 0, 1);
        end else begin
          chk("nibble", 32'(mii_txd), 32'(nq.pop_front()));
        end
      end else begin
        if (in_frame) begin
          in_frame = 1'b0;
          if (have) begin
            chk("tx_en_len", len, cur.len);
            chk("ready_pulses", rdy, cur.rdy);
            chk("frame_done_cnt", dn, cur.done);
            chk("underrun_cnt", un, cur.und);
          end
          gap = 0;
        end
        gap++;
        chk("idle_pulses", {28'h0, frame_done, underrun, mii_tx_er, sif.s_ready}, 0);
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t;
    bit  seen;
    ether_en = 1'b1;
    repeat (3) @(negedge tx_clk);
    chk("rst_txd", 32'(mii_txd), 0);
    chk("rst_tx_en", 32'(mii_tx_en), 0);
    chk("rst_tx_er", 32'(mii_tx_er), 0);
    chk("rst_done", 32'(frame_done), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_gts_ack", 32'(gts_ack), 0);
    chk("rst_ready", 32'(sif.s_ready), 0);
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge tx_clk);

    // ether_en low holds off a pending frame
    ether_en = 1'b0;
    rand_bytes(8);
    send_frame(1'b0, 1'b1, -1, 1'b0, 1'b0, 32'h0);
    seen = 1'b0;
    repeat (12) begin
      @(negedge tx_clk);
      if (mii_tx_en) seen = 1'b1;
    end
    chk("ether_en_hold", 32'(seen), 0);
    ether_en = 1'b1;
    wait_idle();

    // "123456789" with the known FCS 0xCBF43926
    fb.delete();
    for (int i = 0; i < 9; i++) fb.push_back(8'(8'h31 + i));
    send_frame(1'b0, 1'b1, -1, 1'b0, 1'b1, 32'hCBF4_3926);
    wait_idle();

    // short frame padded to 60 bytes
    fb.delete();
    for (int i = 0; i < 10; i++) fb.push_back(8'(i + 1));
    send_frame(1'b1, 1'b1, -1, 1'b0, 1'b0, 32'h0);
    wait_idle();

    // two back-to-back 64-byte frames
    rand_bytes(64);
    send_frame(1'b0, 1'b1, -1, 1'b0, 1'b0, 32'h0);
    rand_bytes(64);
    send_frame(1'b0, 1'b1, IFG, 1'b0, 1'b0, 32'h0);
    wait_idle();

    // underrun after byte 20, then a normal frame after the gap
    rand_bytes(20);
    send_frame(1'b1, 1'b1, -1, 1'b1, 1'b0, 32'h0);
    t = 0;
    while (!underrun && t < 400) begin
      @(negedge tx_clk);
      t++;
    end
    chk("underrun_seen", 32'(underrun), 1);
    rand_bytes(12);
    send_frame(1'b0, 1'b1, IFG, 1'b0, 1'b0, 32'h0);
    wait_idle();

    // graceful stop during frame 1 with frame 2 pending
    rand_bytes(30);
    send_frame(1'b0, 1'b1, -1, 1'b0, 1'b0, 32'h0);
    t = 0;
    while (!mii_tx_en && t < 100) begin
      @(negedge tx_clk);
      t++;
    end
    repeat (20) @(negedge tx_clk);
    gts = 1'b1;
    rand_bytes(8);
    send_frame(1'b0, 1'b1, -1, 1'b0, 1'b0, 32'h0);
    t = 0;
    while (mii_tx_en && t < 400) begin
      @(negedge tx_clk);
      t++;
    end
    chk("gts_frame1_end", 32'(mii_tx_en), 0);
    seen = 1'b0;
    repeat (30) begin
      @(negedge tx_clk);
      if (mii_tx_en) seen = 1'b1;
    end
    chk("gts_no_start", 32'(seen), 0);
    chk("gts_ack_high", 32'(gts_ack), 1);
    gts = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge tx_clk);
      if (mii_tx_en) seen = 1'b1;
    end
    chk("gts_release_start", 32'(seen), 1);
    chk("gts_ack_low", 32'(gts_ack), 0);
    wait_idle();

    // no MAC FCS: padding is not applied either
    rand_bytes(5);
    send_frame(1'b1, 1'b0, -1, 1'b0, 1'b0, 32'h0);
    wait_idle();

    // randomized back-to-back frames with random options
    for (int f = 0; f < 12; f++) begin
      rand_bytes(int'($urandom_range(1, 80)));
      send_frame(1'($urandom), 1'($urandom), (f == 0) ? -1 : IFG, 1'b0, 1'b0, 32'h0);
      wait_src_empty();
    end
    wait_idle();

    // asynchronous reset in PRE cycle 5
    rand_bytes(20);
    send_frame(1'b0, 1'b1, -1, 1'b0, 1'b0, 32'h0);
    t = 0;
    while (!mii_tx_en && t < 100) begin
      @(negedge tx_clk);
      t++;
    end
    repeat (5) @(negedge tx_clk);
    chk("pre_active", 32'(mii_tx_en), 1);
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_tx_en", 32'(mii_tx_en), 0);
    chk("arst_txd", 32'(mii_txd), 0);
    chk("arst_tx_er", 32'(mii_tx_er), 0);
    chk("arst_done", 32'(frame_done), 0);
    chk("arst_underrun", 32'(underrun), 0);
    chk("arst_gts_ack", 32'(gts_ack), 0);
    chk("arst_ready", 32'(sif.s_ready), 0);
    src_q.delete();
    nq.delete();
    fq.delete();
    repeat (2) @(negedge tx_clk);
    rst_n = 1'b1;
    @(negedge tx_clk);
    mon_en = 1'b1;
    rand_bytes(7);
    send_frame(1'b1, 1'b1, -1, 1'b0, 1'b0, 32'h0);
    wait_idle();

    chk("frames_left", fq.size(), 0);
    chk("nibbles_left", nq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
